// File: rtl/isp_pixel_transmitter_pkg.sv
// Shared stream definitions for the ISP pixel pipeline: FSM encodings,
// the transfer qualifier and the default pixel width.
package isp_stream_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // A beat moves only when the source offers it and the sink takes it.
    function automatic logic transfer(input logic valid, input logic ready);
        return valid & ready;
    endfunction
endpackage

// File: rtl/isp_pixel_transmitter_if.sv
// Pixel stream bundle: data plus sof/eol/eof sideband and the
// i_r_ready (valid) / u_r_ready (ready) handshake.
interface isp_pixel_transmitter_if
    import isp_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();
    logic [DATA_WIDTH-1:0] data_out;
    logic                  sof;
    logic                  eol;
    logic                  eof;
    logic                  i_r_ready;
    logic                  u_r_ready;

    modport master (
        output data_out, sof, eol, eof, i_r_ready,
        input  u_r_ready
    );

    modport slave (
        input  data_out, sof, eol, eof, i_r_ready,
        output u_r_ready
    );
endinterface

// File: rtl/isp_pixel_transmitter_raster_counter.sv
// Raster position counter: x walks across a line, y steps down the frame,
// both wrap to zero after the last pixel of the frame.
module raster_counter
    import isp_stream_pkg::*;
#(
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 2,
    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          first,
    output logic          last_in_line,
    output logic          last_in_frame
);
    assign first         = (x == '0) && (y == '0);
    assign last_in_line  = (x == XW'(IMG_WIDTH - 1));
    assign last_in_frame = last_in_line && (y == YW'(IMG_HEIGHT - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (last_in_line) begin
                x <= '0;
                y <= last_in_frame ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/isp_pixel_transmitter.sv
// Ramp-pattern frame source: on start, streams one IMG_WIDTH x IMG_HEIGHT
// frame of seed + linear index pixels, honouring downstream backpressure.
module isp_pixel_transmitter
    import isp_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  frame_done,
    isp_pixel_transmitter_if.master stream
);
    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int IW = DATA_WIDTH + $clog2(IMG_WIDTH * IMG_HEIGHT);

    state_t                state;
    logic                  valid;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic                  first, last_in_line, last_in_frame;
    logic                  xfer, accept, advance;
    logic [IW-1:0]         pix;

    assign xfer    = transfer(valid, stream.u_r_ready);
    assign accept  = (state == ST_IDLE) && start && !abort;
    // The eof beat never advances; the counter is re-cleared on the next start.
    assign advance = (state == ST_SEND) && xfer && !last_in_frame && !abort;

    raster_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_raster (
        .clock        (clock),
        .reset        (reset),
        .clear        (accept),
        .advance      (advance),
        .x            (x),
        .y            (y),
        .first        (first),
        .last_in_line (last_in_line),
        .last_in_frame(last_in_frame)
    );

    // Wide sum so the index never overflows before the final wrap to DATA_WIDTH.
    assign pix = IW'(seed_q) + IW'(y) * IW'(IMG_WIDTH) + IW'(x);

    assign stream.i_r_ready = valid;
    assign stream.data_out  = valid ? pix[DATA_WIDTH-1:0] : '0;
    assign stream.sof       = valid && first;
    assign stream.eol       = valid && last_in_line;
    assign stream.eof       = valid && last_in_frame;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            valid      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            seed_q     <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        seed_q <= seed;
                        state  <= ST_SEND;
                        valid  <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (xfer && last_in_frame) begin
                        state      <= ST_IDLE;
                        valid      <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_isp_pixel_transmitter.sv
// Scoreboard bench for isp_pixel_transmitter: a 4x2 instance for the
// streaming scenarios and a 1x1 instance for the single-pixel frame.
module tb_isp_pixel_transmitter;
    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eol;
        logic       eof;
    } pix_t;

    logic       clock;
    logic       reset;
    logic       start_a, abort_a, busy_a, fd_a;
    logic [7:0] seed_a;
    logic       start_b, abort_b, busy_b, fd_b;
    logic [7:0] seed_b;

    int   errors = 0;
    int   checks = 0;
    int   xfers_a = 0;
    int   fd_cnt = 0;
    pix_t qa[$];
    pix_t held;
    bit   prev_stall = 0;

    isp_pixel_transmitter_if #(.DATA_WIDTH(8)) a_if ();
    isp_pixel_transmitter_if #(.DATA_WIDTH(8)) b_if ();

    isp_pixel_transmitter #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .abort(abort_a), .seed(seed_a),
        .busy(busy_a), .frame_done(fd_a), .stream(a_if)
    );

    isp_pixel_transmitter #(.DATA_WIDTH(8), .IMG_WIDTH(1), .IMG_HEIGHT(1)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .abort(abort_b), .seed(seed_b),
        .busy(busy_b), .frame_done(fd_b), .stream(b_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clock) begin
        pix_t cur, exp_p;
        cur = '{a_if.data_out, a_if.sof, a_if.eol, a_if.eof};
        if (fd_a) fd_cnt++;
        if (prev_stall && a_if.i_r_ready && !reset) begin
            checks++;
            if (cur !== held) begin
                errors++;
                $display("FAIL stall_hold: got %h want %h", cur, held);
            end
        end
        if (a_if.i_r_ready && a_if.u_r_ready && !reset) begin
            checks++;
            xfers_a++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL extra_pixel: got %h want none", cur);
            end else begin
                exp_p = qa.pop_front();
                if (cur !== exp_p) begin
                    errors++;
                    $display("FAIL pixel: got d=%h sof=%b eol=%b eof=%b want d=%h sof=%b eol=%b eof=%b",
                             cur.d, cur.sof, cur.eol, cur.eof, exp_p.d, exp_p.sof, exp_p.eol, exp_p.eof);
                end
            end
        end
        prev_stall = a_if.i_r_ready && !a_if.u_r_ready && !reset;
        held = cur;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Expected first n pixels of a 4x2 frame from seed s.
    task automatic push_frame(input logic [7:0] s, input int n);
        int k = 0;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) begin
                if (k < n)
                    qa.push_back('{8'(s + 8'(y * 4 + x)), (x == 0 && y == 0), (x == 3), (x == 3 && y == 1)});
                k++;
            end
    endtask

    task automatic drain(input bit toggle, input bit mid_start, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (qa.size() == 0) begin
                ok = 1;
                break;
            end
            a_if.u_r_ready = toggle ? ((i % 3) == 0) : 1'b1;
            if (mid_start && i == 2) begin
                start_a = 1'b1;
                seed_a  = 8'h40;
            end else begin
                start_a = 1'b0;
            end
            cyc();
        end
        start_a = 1'b0;
        a_if.u_r_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({a_if.i_r_ready, busy_a, fd_a, a_if.sof, a_if.eol, a_if.eof, a_if.data_out} !== 14'h0) begin
            errors++;
            $display("FAIL reset_a: got irr=%b busy=%b fd=%b flags=%b%b%b d=%h want all 0",
                     a_if.i_r_ready, busy_a, fd_a, a_if.sof, a_if.eol, a_if.eof, a_if.data_out);
        end
        checks++;
        if ({b_if.i_r_ready, busy_b, fd_b, b_if.data_out} !== 11'h0) begin
            errors++;
            $display("FAIL reset_b: got irr=%b busy=%b fd=%b d=%h want all 0",
                     b_if.i_r_ready, busy_b, fd_b, b_if.data_out);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic frame_end_checks(input string name, input int want_xfers);
        checks++;
        if ({fd_a, busy_a, a_if.i_r_ready} !== 3'b100) begin
            errors++;
            $display("FAIL %s_end: got fd=%b busy=%b irr=%b want fd=1 busy=0 irr=0", name, fd_a, busy_a, a_if.i_r_ready);
        end
        checks++;
        if (xfers_a !== want_xfers) begin
            errors++;
            $display("FAIL %s_count: got %0d want %0d", name, xfers_a, want_xfers);
        end
    endtask

    task automatic test_basic();
        bit ok;
        xfers_a = 0;
        fd_cnt = 0;
        push_frame(8'hFE, 8);
        start_a = 1'b1;
        seed_a = 8'hFE;
        cyc();
        start_a = 1'b0;
        checks++;
        if ({a_if.i_r_ready, busy_a, a_if.data_out, a_if.sof} !== {2'b11, 8'hFE, 1'b1}) begin
            errors++;
            $display("FAIL basic_first: got irr=%b busy=%b d=%h sof=%b want 1 1 fe 1",
                     a_if.i_r_ready, busy_a, a_if.data_out, a_if.sof);
        end
        drain(1'b0, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: got %0d pending want 0", qa.size());
        end
        frame_end_checks("basic", 8);
        cyc();
        checks++;
        if (fd_a !== 1'b0 || fd_cnt !== 1) begin
            errors++;
            $display("FAIL basic_fd_pulse: got fd=%b count=%0d want 0 1", fd_a, fd_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        xfers_a = 0;
        fd_cnt = 0;
        push_frame(8'hFE, 8);
        start_a = 1'b1;
        seed_a = 8'hFE;
        cyc();
        start_a = 1'b0;
        drain(1'b1, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout: got %0d pending want 0", qa.size());
        end
        frame_end_checks("bp", 8);
        cyc();
        cyc();
        checks++;
        if (fd_cnt !== 1) begin
            errors++;
            $display("FAIL bp_fd_once: got %0d want 1", fd_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        xfers_a = 0;
        push_frame(8'hFE, 8);
        start_a = 1'b1;
        seed_a = 8'hFE;
        cyc();
        start_a = 1'b0;
        drain(1'b0, 1'b1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d pending want 0", qa.size());
        end
        frame_end_checks("b2b_first", 8);
        // start during the frame_done cycle
        xfers_a = 0;
        push_frame(8'h20, 8);
        start_a = 1'b1;
        seed_a = 8'h20;
        cyc();
        start_a = 1'b0;
        checks++;
        if ({a_if.i_r_ready, a_if.data_out, a_if.sof} !== {1'b1, 8'h20, 1'b1}) begin
            errors++;
            $display("FAIL b2b_restart: got irr=%b d=%h sof=%b want 1 20 1", a_if.i_r_ready, a_if.data_out, a_if.sof);
        end
        drain(1'b0, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b2_timeout: got %0d pending want 0", qa.size());
        end
        frame_end_checks("b2b_second", 8);
        cyc();
    endtask

    task automatic test_abort();
        xfers_a = 0;
        fd_cnt = 0;
        push_frame(8'hFE, 3);
        start_a = 1'b1;
        seed_a = 8'hFE;
        cyc();
        start_a = 1'b0;
        cyc();
        cyc();
        abort_a = 1'b1;
        cyc();
        abort_a = 1'b0;
        checks++;
        if ({a_if.i_r_ready, busy_a, fd_a} !== 3'b000) begin
            errors++;
            $display("FAIL abort_stop: got irr=%b busy=%b fd=%b want 0 0 0", a_if.i_r_ready, busy_a, fd_a);
        end
        checks++;
        if (xfers_a !== 3 || qa.size() !== 0) begin
            errors++;
            $display("FAIL abort_count: got %0d xfers %0d pending want 3 0", xfers_a, qa.size());
        end
        cyc();
        checks++;
        if (fd_cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_fd: got %0d want 0", fd_cnt);
        end
        abort_a = 1'b1;
        start_a = 1'b1;
        cyc();
        abort_a = 1'b0;
        start_a = 1'b0;
        checks++;
        if ({a_if.i_r_ready, busy_a} !== 2'b00) begin
            errors++;
            $display("FAIL abort_start_idle: got irr=%b busy=%b want 0 0", a_if.i_r_ready, busy_a);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        bit ok;
        xfers_a = 0;
        push_frame(8'hFE, 8);
        start_a = 1'b1;
        seed_a = 8'hFE;
        cyc();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        reset = 1'b1;
        a_if.u_r_ready = 1'b0;
        cyc();
        checks++;
        if ({a_if.i_r_ready, busy_a, fd_a, a_if.sof, a_if.eol, a_if.eof, a_if.data_out} !== 14'h0) begin
            errors++;
            $display("FAIL reset_mid: got irr=%b busy=%b fd=%b flags=%b%b%b d=%h want all 0",
                     a_if.i_r_ready, busy_a, fd_a, a_if.sof, a_if.eol, a_if.eof, a_if.data_out);
        end
        checks++;
        if (xfers_a !== 5) begin
            errors++;
            $display("FAIL reset_mid_count: got %0d want 5", xfers_a);
        end
        qa.delete();
        reset = 1'b0;
        a_if.u_r_ready = 1'b1;
        cyc();
        xfers_a = 0;
        push_frame(8'h10, 8);
        start_a = 1'b1;
        seed_a = 8'h10;
        cyc();
        start_a = 1'b0;
        drain(1'b0, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid_timeout: got %0d pending want 0", qa.size());
        end
        frame_end_checks("after_reset", 8);
        cyc();
    endtask

    task automatic test_one_pixel();
        start_b = 1'b1;
        seed_b = 8'h7A;
        cyc();
        start_b = 1'b0;
        checks++;
        if ({b_if.i_r_ready, b_if.data_out, b_if.sof, b_if.eol, b_if.eof} !== {1'b1, 8'h7A, 3'b111}) begin
            errors++;
            $display("FAIL one_pixel: got irr=%b d=%h flags=%b%b%b want 1 7a 111",
                     b_if.i_r_ready, b_if.data_out, b_if.sof, b_if.eol, b_if.eof);
        end
        cyc();
        checks++;
        if ({fd_b, busy_b, b_if.i_r_ready} !== 3'b100) begin
            errors++;
            $display("FAIL one_pixel_end: got fd=%b busy=%b irr=%b want 1 0 0", fd_b, busy_b, b_if.i_r_ready);
        end
        cyc();
        checks++;
        if (fd_b !== 1'b0) begin
            errors++;
            $display("FAIL one_pixel_fd_pulse: got %b want 0", fd_b);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; seed_a = 8'h00;
        start_b = 1'b0; abort_b = 1'b0; seed_b = 8'h00;
        a_if.u_r_ready = 1'b1;
        b_if.u_r_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_one_pixel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
